mem_arbiter: RTL

//  Shares the single byte-wide RAM port between instruction fetch (IF) and the data-memory stage (MEM).

---
 rtl/mem_arbiter_pkg.sv | 35 +++
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the byte-serial RAM arbiter: FSM states, access sizes, latched request.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_IF_RD = 2'd1,
    ARB_ME_RD = 2'd2,
    ARB_ME_WR = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  localparam logic       RAM_WRITE = 1'b1;
  localparam logic       RAM_READ  = 1'b0;
  localparam logic [2:0] IF_BYTES  = 3'd4;

  typedef struct packed {
    logic [2:0]      nbytes;
    logic [3:0][7:0] wdata;
  } acc_t;

  // Size code 3 is not a legal MEM size and is served as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (mem_size_e'(size))
      MEM_BYTE: return 3'd1;
      MEM_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester (IF/MEM) handshakes and the byte-wide RAM port seen by the arbiter.
interface mem_arbiter_if #(parameter int ADDR_W = 32);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_data;
  logic              if_done;
  logic              if_stall_req;

  logic              me_req;
  logic              me_we;
  logic [1:0]        me_size;
  logic [ADDR_W-1:0] me_addr;
  logic [31:0]       me_wdata;
  logic [31:0]       me_rdata;
  logic              me_done;
  logic              me_stall_req;

  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout;
  logic              ram_wr;
  logic [7:0]        ram_din;

  modport slave (
    input  if_req, if_addr, me_req, me_we, me_size, me_addr, me_wdata, ram_din,
    output if_data, if_done, if_stall_req, me_rdata, me_done, me_stall_req,
           ram_a, ram_dout, ram_wr
  );

  modport master (
    output if_req, if_addr, me_req, me_we, me_size, me_addr, me_wdata, ram_din,
    input  if_data, if_done, if_stall_req, me_rdata, me_done, me_stall_req,
           ram_a, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates IF and MEM onto one byte-wide RAM port; serialises accesses little-endian
// and assembles read words, with MEM taking priority when both request in IDLE.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic clk,
  input  logic rst,
  mem_arbiter_if.slave bus
);

  arb_state_e        state, state_nx;
  logic [2:0]        k;
  logic [ADDR_W-1:0] addr_q;
  acc_t              acc;
  logic [3:0][7:0]   rbuf, rmerge;
  logic [1:0]        last_lane;

  logic              if_done, me_done, ram_wr;
  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout;

  always_comb begin
    state_nx  = state;
    ram_a     = '0;
    ram_dout  = '0;
    ram_wr    = RAM_READ;
    if_done   = 1'b0;
    me_done   = 1'b0;
    // Final read byte is still on ram_din in the done cycle; merge it without a register stage.
    last_lane = 2'(acc.nbytes - 3'd1);
    rmerge    = rbuf;
    rmerge[last_lane] = bus.ram_din;
    case (state)
      ARB_IDLE: begin
        if (bus.me_req)      state_nx = bus.me_we ? ARB_ME_WR : ARB_ME_RD;
        else if (bus.if_req) state_nx = ARB_IF_RD;
      end
      ARB_IF_RD, ARB_ME_RD: begin
        if (k == acc.nbytes) begin
          if_done  = (state == ARB_IF_RD);
          me_done  = (state == ARB_ME_RD);
          state_nx = ARB_IDLE;
        end else begin
          ram_a = addr_q + ADDR_W'(k);
        end
      end
      ARB_ME_WR: begin
        ram_a    = addr_q + ADDR_W'(k);
        ram_dout = acc.wdata[k[1:0]];
        ram_wr   = RAM_WRITE;
        if (k == acc.nbytes - 3'd1) begin
          me_done  = 1'b1;
          state_nx = ARB_IDLE;
        end
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ARB_IDLE;
      k      <= '0;
      addr_q <= '0;
      acc    <= '0;
      rbuf   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ARB_IDLE: begin
          if (state_nx != ARB_IDLE) begin
            k          <= '0;
            rbuf       <= '0;
            addr_q     <= bus.me_req ? bus.me_addr : bus.if_addr;
            acc.nbytes <= bus.me_req ? size_bytes(bus.me_size) : IF_BYTES;
            acc.wdata  <= bus.me_wdata;
          end
        end
        ARB_IF_RD, ARB_ME_RD: begin
          if (k != acc.nbytes) begin
            k <= k + 3'd1;
            // Byte for address k-1 returns while address k is on the bus.
            if (k != 3'd0) rbuf[2'(k - 3'd1)] <= bus.ram_din;
          end
        end
        ARB_ME_WR: k <= k + 3'd1;
        default: ;
      endcase
    end
  end

  assign bus.ram_a        = ram_a;
  assign bus.ram_dout     = ram_dout;
  assign bus.ram_wr       = ram_wr;
  assign bus.if_done      = if_done;
  assign bus.me_done      = me_done;
  assign bus.if_data      = if_done ? rmerge : 32'h0;
  assign bus.me_rdata     = me_done ? rmerge : 32'h0;
  assign bus.if_stall_req = bus.if_req & ~if_done;
  assign bus.me_stall_req = bus.me_req & ~me_done;

endmodule
